// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the RAM bus master: FSM states, default widths
// and the RAM write-enable encoding.
package ram_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_BLEN_W = 4;

  localparam logic WE_WRITE = 1'b0;
  localparam logic WE_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_READ,
    ST_TURN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ram_bus_master_if.sv
// Host-side command handshake of the RAM bus master. The master modport is the
// view of the bus master itself; the slave modport is the view of the host.
interface ram_bus_master_if
  import ram_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BLEN_W = DEF_BLEN_W
);

  logic              req;
  logic              cmd_wr;
  logic [ADDR_W-1:0] start_addr;
  logic [BLEN_W-1:0] burst_len;
  logic              addr_dir;
  logic [DATA_W-1:0] wdata;
  logic              wdata_rdy;
  logic [DATA_W-1:0] rdata;
  logic              rdata_vld;
  logic              busy;
  logic              done;

  modport master (
    input  req, cmd_wr, start_addr, burst_len, addr_dir, wdata,
    output wdata_rdy, rdata, rdata_vld, busy, done
  );

  modport slave (
    output req, cmd_wr, start_addr, burst_len, addr_dir, wdata,
    input  wdata_rdy, rdata, rdata_vld, busy, done
  );

endinterface

// File: rtl/ram_bus_io.sv
// RAM data-pin interface: holds the write word, drives the shared bus when
// enabled and captures read data on request.
module ram_bus_io #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_cap,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_drive_en,
  input  logic              i_sample_en,
  output logic [DATA_W-1:0] o_rdata,
  inout  wire  [DATA_W-1:0] io_data
);

  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (i_wr_cap)    r_wdata <= i_wdata;
      if (i_sample_en) r_rdata <= io_data;
    end
  end

  assign io_data = i_drive_en ? r_wdata : {DATA_W{1'bz}};
  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_bus_master.sv
// Clocked initiator for the single-port RAM: turns host single/burst commands
// into registered address, write-enable and bus-direction sequences.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned BLEN_W   = DEF_BLEN_W,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_bus_master_if.master  bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int unsigned WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  state_e            r_state,     w_state;
  logic              r_cmd_wr,    w_cmd_wr;
  logic              r_dir,       w_dir;
  logic [ADDR_W-1:0] r_addr,      w_addr;
  logic [BLEN_W-1:0] r_left,      w_left;
  logic [WAIT_W-1:0] r_wait,      w_wait;
  logic              r_ram_we,    w_ram_we;
  logic              r_drive_en,  w_drive_en;
  logic              r_wdata_rdy, w_wdata_rdy;
  logic              r_rdata_vld, w_rdata_vld;
  logic              r_busy,      w_busy;
  logic              r_done,      w_done;
  logic              w_last_cyc;
  logic              w_wr_cap;
  logic              w_sample_en;
  logic [DATA_W-1:0] w_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_wr    <= 1'b0;
      r_dir       <= 1'b0;
      r_addr      <= '0;
      r_left      <= '0;
      r_wait      <= '0;
      r_ram_we    <= WE_READ;
      r_drive_en  <= 1'b0;
      r_wdata_rdy <= 1'b0;
      r_rdata_vld <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cmd_wr    <= w_cmd_wr;
      r_dir       <= w_dir;
      r_addr      <= w_addr;
      r_left      <= w_left;
      r_wait      <= w_wait;
      r_ram_we    <= w_ram_we;
      r_drive_en  <= w_drive_en;
      r_wdata_rdy <= w_wdata_rdy;
      r_rdata_vld <= w_rdata_vld;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  // Next state and counters; every registered output is decoded from the next state.
  always_comb begin
    w_state     = r_state;
    w_cmd_wr    = r_cmd_wr;
    w_dir       = r_dir;
    w_addr      = r_addr;
    w_left      = r_left;
    w_wait      = r_wait;
    w_wr_cap    = 1'b0;
    w_sample_en = 1'b0;
    w_last_cyc  = (r_wait == WAIT_W'(WAIT_CYC - 1));

    unique case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_cmd_wr = bus.cmd_wr;
          w_dir    = bus.addr_dir;
          w_addr   = bus.start_addr;
          w_left   = bus.burst_len;
          w_state  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        w_wr_cap = r_cmd_wr;
        w_wait   = '0;
        w_state  = r_cmd_wr ? ST_WRITE : ST_READ;
      end
      ST_WRITE, ST_READ: begin
        if (w_last_cyc) begin
          w_sample_en = (r_state == ST_READ);
          if (r_left != '0) begin
            w_left  = r_left - BLEN_W'(1);
            w_addr  = r_dir ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
            w_state = ST_ADDR;
          end else begin
            w_state = ST_TURN;
          end
        end else begin
          w_wait = r_wait + WAIT_W'(1);
        end
      end
      ST_TURN: w_state = ST_DONE;
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase

    w_ram_we    = (w_state == ST_WRITE) ? WE_WRITE : WE_READ;
    w_drive_en  = (w_state == ST_WRITE);
    w_wdata_rdy = (w_state == ST_ADDR) && w_cmd_wr;
    w_busy      = (w_state != ST_IDLE);
    w_done      = (w_state == ST_DONE);
    w_rdata_vld = w_sample_en;
  end

  ram_bus_io #(.DATA_W(DATA_W)) u_io (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_cap    (w_wr_cap),
    .i_wdata     (bus.wdata),
    .i_drive_en  (r_drive_en),
    .i_sample_en (w_sample_en),
    .o_rdata     (w_rdata),
    .io_data     (ram_data)
  );

  assign ram_we        = r_ram_we;
  assign ram_addr      = r_addr;
  assign bus.wdata_rdy = r_wdata_rdy;
  assign bus.rdata     = w_rdata;
  assign bus.rdata_vld = r_rdata_vld;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  a_wait_cyc_legal: assert property (@(posedge clk) WAIT_CYC >= 1);

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: two instances (WAIT_CYC=1 and 3), each with a RAM
// model on its bus, checked against an address/data reference model.
module tb_ram_bus_master;
  import ram_bus_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          sel;
  logic          req, cmd_wr, addr_dir;
  logic [AW-1:0] start_addr;
  logic [BW-1:0] burst_len;
  logic [DW-1:0] wdata;

  ram_bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW)) bus1 ();
  ram_bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW)) bus3 ();

  assign bus1.req = req & ~sel;
  assign bus3.req = req & sel;
  assign bus1.cmd_wr = cmd_wr;         assign bus3.cmd_wr = cmd_wr;
  assign bus1.start_addr = start_addr; assign bus3.start_addr = start_addr;
  assign bus1.burst_len = burst_len;   assign bus3.burst_len = burst_len;
  assign bus1.addr_dir = addr_dir;     assign bus3.addr_dir = addr_dir;
  assign bus1.wdata = wdata;           assign bus3.wdata = wdata;

  logic          ram_we1, ram_we3;
  logic [AW-1:0] ram_addr1, ram_addr3;
  wire  [DW-1:0] ram_data1, ram_data3;

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW), .WAIT_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1.master),
    .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_data(ram_data1));

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW), .WAIT_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.master),
    .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_data(ram_data3));

  // RAM models: drive the bus while we=1, store on the edge while we=0.
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] mem3 [1024];
  assign ram_data1 = ram_we1 ? mem1[ram_addr1] : {DW{1'bz}};
  assign ram_data3 = ram_we3 ? mem3[ram_addr3] : {DW{1'bz}};
  always @(posedge clk) if (!ram_we1) mem1[ram_addr1] <= ram_data1;
  always @(posedge clk) if (!ram_we3) mem3[ram_addr3] <= ram_data3;

  wire          m_we    = sel ? ram_we3      : ram_we1;
  wire [AW-1:0] m_addr  = sel ? ram_addr3    : ram_addr1;
  wire [DW-1:0] m_data  = sel ? ram_data3    : ram_data1;
  wire [DW-1:0] m_rdata = sel ? bus3.rdata   : bus1.rdata;
  wire          m_vld   = sel ? bus3.rdata_vld : bus1.rdata_vld;
  wire          m_busy  = sel ? bus3.busy    : bus1.busy;
  wire          m_done  = sel ? bus3.done    : bus1.done;
  wire          m_wrdy  = sel ? bus3.wdata_rdy : bus1.wdata_rdy;

  // Reference memory contents per instance; ref_vld marks words with known content.
  logic [DW-1:0] ref_mem [2][1024];
  bit            ref_vld [2][1024];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [DW-1:0] w0, input int k);
    if (k < 4) return w0 >> (4 * k);
    return w0 ^ 16'(k * 257);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] a0, input logic dir, input int k);
    int v;
    v = dir ? (int'(a0) - k) : (int'(a0) + k);
    return 10'((((v % 1024) + 1024) % 1024));
  endfunction

  // Issue one command from a negedge and check it cycle by cycle against the model.
  task automatic run_cmd(input logic s, input logic wr, input logic [AW-1:0] a0,
                         input logic [BW-1:0] bl, input logic dir, input logic [DW-1:0] w0,
                         input int exp_done, input string tag);
    int n, w, si, cyc, done_cyc, vld_cyc, n_done, busy_bad, widx, n_rdy;
    logic [AW+DW-1:0] wq[$];
    logic [DW-1:0]    rq[$];
    logic [AW-1:0]    a;
    n = int'(bl) + 1; w = s ? 3 : 1; si = s ? 1 : 0;
    cyc = 0; done_cyc = -1; vld_cyc = -1; n_done = 0; busy_bad = 0; widx = 0; n_rdy = 0;
    sel = s; cmd_wr = wr; start_addr = a0; burst_len = bl; addr_dir = dir;
    wdata = 16'hDEAD; req = 1'b1;
    @(posedge clk);
    while (cyc < 200 && (done_cyc < 0 || cyc <= done_cyc)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req = 1'b0;
        cmd_wr = 1'($urandom); start_addr = 10'($urandom);
        burst_len = 4'($urandom); addr_dir = 1'($urandom);
      end
      if (!m_we) wq.push_back({m_addr, m_data});
      if (m_vld) begin
        rq.push_back(m_rdata);
        if (vld_cyc < 0) vld_cyc = cyc;
      end
      if (m_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0 || cyc == done_cyc) busy_bad += m_busy ? 0 : 1;
      else                                 busy_bad += m_busy ? 1 : 0;
      if (m_wrdy) begin
        wdata = word_of(w0, widx);
        widx++;
        n_rdy++;
      end
    end
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_busy_window"}, busy_bad, 0);
    if (wr) begin
      chk({tag, "_wdata_rdy_count"}, n_rdy, n);
      chk({tag, "_write_cycles"}, wq.size(), n * w);
      chk({tag, "_rdata_vld_count"}, rq.size(), 0);
      for (int k = 0; k < n; k++) begin
        a = addr_of(a0, dir, k);
        for (int j = 0; j < w; j++)
          if (k * w + j < wq.size())
            chk($sformatf("%s_wr%0d_%0d", tag, k, j), wq[k * w + j], {a, word_of(w0, k)});
        ref_mem[si][a] = word_of(w0, k);
        ref_vld[si][a] = 1'b1;
      end
    end else begin
      chk({tag, "_rdata_vld_count"}, rq.size(), n);
      chk({tag, "_bus_driven"}, wq.size(), 0);
      chk({tag, "_first_vld_cycle"}, vld_cyc, w + 2);
      for (int k = 0; k < n && k < rq.size(); k++) begin
        a = addr_of(a0, dir, k);
        if (ref_vld[si][a]) chk($sformatf("%s_rd%0d", tag, k), rq[k], ref_mem[si][a]);
      end
    end
  endtask

  typedef struct {
    logic          s;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] blen;
    logic          dir;
    logic [DW-1:0] w0;
    int            exp_done;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0]   busy_bits, done_bits;
    int            nd;
    logic          rwr, rdir, last_dir;
    logic [AW-1:0] raddr, last_addr;
    logic [BW-1:0] rbl, last_bl;
    bit            have_wr;

    vecs[0] = '{1'b0, 1'b1, 10'h004, 4'd2,  1'b1, 16'hFFFF, 8};
    vecs[1] = '{1'b0, 1'b0, 10'h004, 4'd2,  1'b1, 16'h0000, 8};
    vecs[2] = '{1'b0, 1'b1, 10'h3FF, 4'd1,  1'b0, 16'hA5A5, 6};
    vecs[3] = '{1'b0, 1'b0, 10'h3FF, 4'd1,  1'b0, 16'h0000, 6};
    vecs[4] = '{1'b0, 1'b1, 10'h001, 4'd15, 1'b1, 16'h1234, 34};
    vecs[5] = '{1'b0, 1'b0, 10'h001, 4'd15, 1'b1, 16'h0000, 34};
    vecs[6] = '{1'b0, 1'b1, 10'h200, 4'd0,  1'b0, 16'hBEEF, 4};
    vecs[7] = '{1'b0, 1'b0, 10'h200, 4'd0,  1'b0, 16'h0000, 4};
    vecs[8] = '{1'b1, 1'b1, 10'h050, 4'd1,  1'b0, 16'hC3C3, 10};
    vecs[9] = '{1'b1, 1'b0, 10'h050, 4'd1,  1'b0, 16'h0000, 10};

    sel = 1'b0; req = 1'b1; cmd_wr = 1'b1; start_addr = 10'h155; burst_len = 4'd3;
    addr_dir = 1'b0; wdata = 16'h5555; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",      bus1.busy, 1'b0);
    chk("rst_done",      bus1.done, 1'b0);
    chk("rst_ram_we",    ram_we1, 1'b1);
    chk("rst_ram_addr",  ram_addr1, 10'h000);
    chk("rst_wdata_rdy", bus1.wdata_rdy, 1'b0);
    chk("rst_rdata_vld", bus1.rdata_vld, 1'b0);
    chk("rst_rdata",     bus1.rdata, 16'h0000);
    chk("rst3_ram_we",   ram_we3, 1'b1);
    chk("rst3_busy",     bus3.busy, 1'b0);
    rst_n = 1'b1; req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_cmd(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].blen, vecs[i].dir,
              vecs[i].w0, vecs[i].exp_done, $sformatf("vec%0d", i));

    // Random commands; reads mostly revisit the previous write's region.
    have_wr = 1'b0; last_addr = '0; last_bl = '0; last_dir = 1'b0;
    for (int i = 0; i < 24; i++) begin
      rwr = 1'($urandom); raddr = 10'($urandom); rbl = 4'($urandom_range(0, 7));
      rdir = 1'($urandom);
      if (!rwr && have_wr && ($urandom_range(0, 3) != 0)) begin
        raddr = last_addr; rbl = last_bl; rdir = last_dir;
      end
      if (rwr) begin
        have_wr = 1'b1; last_addr = raddr; last_bl = rbl; last_dir = rdir;
      end
      run_cmd(1'b0, rwr, raddr, rbl, rdir, 16'($urandom),
              2 * (int'(rbl) + 1) + 2, $sformatf("rnd%0d", i));
    end

    // req held high across a command: only the first IDLE cycle accepts again.
    sel = 1'b0; cmd_wr = 1'b0; start_addr = 10'h004; burst_len = 4'd0; addr_dir = 1'b0;
    req = 1'b1; busy_bits = '0; done_bits = '0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 6) req = 1'b0;
      busy_bits[c-1] = bus1.busy;
      done_bits[c-1] = bus1.done;
    end
    chk("hold_req_busy_trace", busy_bits, 12'h1EF);
    chk("hold_req_done_trace", done_bits, 12'h108);

    // Reset during the WRITE cycle of the second word of a three-word burst.
    sel = 1'b0; cmd_wr = 1'b1; start_addr = 10'h100; burst_len = 4'd2; addr_dir = 1'b0;
    wdata = 16'hDEAD; req = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (bus1.wdata_rdy) wdata = (c == 1) ? 16'h1111 : 16'h2222;
    end
    chk("mid_rst_word2_on_bus", {ram_we1, ram_addr1, ram_data1}, {1'b0, 10'h101, 16'h2222});
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ram_we",    ram_we1, 1'b1);
    chk("mid_rst_busy",      bus1.busy, 1'b0);
    chk("mid_rst_done",      bus1.done, 1'b0);
    chk("mid_rst_ram_addr",  ram_addr1, 10'h000);
    chk("mid_rst_wdata_rdy", bus1.wdata_rdy, 1'b0);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nd += bus1.done ? 1 : 0;
    end
    chk("mid_rst_no_done", nd, 0);
    // Word 2 saw a full write strobe before reset took effect; word 3 never did.
    ref_mem[0][10'h100] = 16'h1111; ref_vld[0][10'h100] = 1'b1;
    ref_mem[0][10'h101] = 16'h2222; ref_vld[0][10'h101] = 1'b1;
    run_cmd(1'b0, 1'b0, 10'h100, 4'd0, 1'b0, 16'h0000, 4, "mid_rst_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
Synchronous initiator for the 1K x 16 single-port RAM bus: `we` is active-low write, the address is 10 bits, and `data` is a shared 16-bit tri-state line. It accepts single or burst read/write commands from a host handshake and sequences address, write-enable and bus direction toward the RAM. It is the clocked replacement for the hand-driven bus stimulus, and it sits between the datapath and the ram block.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 16, RAM data width
BLEN_W, 4, burst length field width (bursts of 1..2^BLEN_W words)
WAIT_CYC, 1, cycles each word is held on the bus (>=1; 0 is illegal, simulation assertion)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
req  in  1  command request; sampled only when busy=0
cmd_wr  in  1  1=write burst, 0=read burst
start_addr  in  ADDR_W  first word address
burst_len  in  BLEN_W  word count minus 1
addr_dir  in  1  0=increment, 1=decrement
wdata  in  DATA_W  write word; sampled on the edge ending a wdata_rdy cycle
wdata_rdy  out  1  host must present the next write word this cycle
rdata  out  DATA_W  last word read
rdata_vld  out  1  one-cycle pulse, rdata valid
busy  out  1  command in progress
done  out  1  one-cycle pulse at end of command
ram_we  out  1  to RAM `we`: 0=write, 1=read
ram_addr  out  ADDR_W  to RAM address
ram_data  inout  DATA_W  to RAM data; driven only while ram_we=0, else high-Z

Behaviour:
- Reset values, applied at the edge with rst_n=0: state IDLE, ram_we=1, ram_addr=0, ram_data high-Z, busy=0, done=0, wdata_rdy=0, rdata_vld=0, rdata=0, counters=0.
- All outputs and the tri-state enable are registered from one state register. ram_data is driven only in WRITE, and ram_we=0 only in WRITE, so there is no bus contention.
- States: IDLE, ADDR, WRITE, READ, TURN, DONE.
- IDLE: on req=1, latch cmd_wr, start_addr, burst_len and addr_dir, then go to ADDR. busy=1 from the next cycle.
- ADDR: ram_addr = current address, ram_we=1, bus released. For a write, wdata_rdy=1 and wdata is captured at the end of this cycle. Next state is WRITE (write) or READ (read).
- WRITE: ram_we=0, drive the captured word for WAIT_CYC cycles.
- READ: ram_we=1 for WAIT_CYC cycles; sample ram_data at the end of the last cycle. rdata and rdata_vld=1 appear in the following cycle.
- After the last WRITE/READ cycle:
  - words remaining: step the address (+1 or -1, modulo 2^ADDR_W) and go to ADDR;
  - otherwise go to TURN.
- TURN: one cycle, ram_we=1, bus released. Next state DONE.
- DONE: done=1, busy=1. Next state IDLE, where busy=0.
- Latency with WAIT_CYC=1, where c0 is the edge sampling req:
  - single write: ADDR c1, WRITE c2, TURN c3, done c4;
  - single read: ADDR c1, READ c2, rdata_vld c3, done c4.
  - Burst of N words: done at c(2N+2).
  - The earliest accepted next req is sampled at the end of c5 (first IDLE cycle).
- Boundaries:
  - address wrap: 0x3FF+1 -> 0x000, 0x000-1 -> 0x3FF;
  - req while busy, including the DONE cycle: ignored, no queuing;
  - burst_len = max gives 2^BLEN_W words;
  - command inputs change after acceptance: no effect.
- Reset mid-command: at the next edge all outputs return to their reset values and the bus is released. The partial burst is abandoned and done is not pulsed.

Decomposition:
- Package ram_bus_pkg: state enum, ADDR_W/DATA_W defaults, constants WE_WRITE=1'b0 and WE_READ=1'b1.
- Sub-module ram_bus_io: tri-state driver plus read-sample register, controlled by drive_en/sample_en from the FSM.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=1 -> busy=0, ram_we=1, ram_data=Z, no done.
- Burst write: start_addr=0x004, burst_len=2, addr_dir=1, wdata FFFF/0FFF/00FF -> ram_addr 004, 003, 002.
  - Exactly one ram_we=0 cycle per word, with matching data on the bus.
  - done pulse at c8.
- Burst read of the same region -> three rdata_vld pulses carrying FFFF, 0FFF, 00FF in order; bus never driven by the master.
- Wrap: write burst_len=1, addr_dir=0 from 0x3FF -> addresses 3FF then 000; the readback matches.
- Protocol: req held high throughout a command -> second command accepted only at the first IDLE cycle.
- Protocol: WAIT_CYC=3 -> ram_we=0 held exactly 3 cycles per word.
- Mid-burst reset: rst_n=0 during the WRITE of word 2 -> next edge ram_we=1, ram_data=Z, busy=0, no done; a following single read returns word 1 only.
